// File: rtl/openofdm_rx_byte_to_axis_if.sv
// AXI4-Stream channel carrying framed RX packets (header, payload, trailer beats).
interface openofdm_rx_byte_to_axis_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/openofdm_rx_byte_to_axis.sv
// Frames OpenOFDM RX decoded bytes into an AXI4-Stream: header beat, LE payload beats,
// trailer beat with FCS/abort/truncation flags, buffered through a FWFT FIFO.
//
// state     | meaning
// S_IDLE    | waiting for a valid header strobe
// S_PAYLOAD | packing payload bytes into 32-bit words
// S_TRAILER | writing the trailer beat (stalls while the FIFO is full)
module openofdm_rx_byte_to_axis #(
  parameter int          FIFO_DEPTH_LOG2 = 6,
  parameter logic [15:0] MAX_LEN         = 16'd4095
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic                              pkt_header_valid_strobe,
  input  logic                              pkt_header_valid,
  input  logic [7:0]                        pkt_rate,
  input  logic [15:0]                       pkt_len,
  input  logic                              ht_aggr,
  input  logic                              ht_sgi,
  input  logic                              byte_out_strobe,
  input  logic [7:0]                        byte_out,
  input  logic                              fcs_out_strobe,
  input  logic                              fcs_ok,
  openofdm_rx_byte_to_axis_if.master        m_axis,
  output logic                              busy,
  output logic                              pkt_drop_strobe,
  output logic [15:0]                       overflow_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PAYLOAD = 2'd1;
  localparam logic [1:0] S_TRAILER = 2'd2;

  localparam int                     DEPTH    = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] PTR_ONE  = {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [FIFO_DEPTH_LOG2:0] PTR_FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  logic [1:0]  state;
  logic        pend_vld;
  logic [31:0] pend_data;
  logic [23:0] pack_word;
  logic [1:0]  pack_cnt;
  logic [15:0] byte_count;
  logic        trunc;
  logic        aborted;
  logic        fcs_ok_reg;

  logic [32:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG2:0]   wr_ptr;
  logic [FIFO_DEPTH_LOG2:0]   rd_ptr;
  logic                       empty;
  logic                       full;
  logic                       fifo_pop;
  logic                       can_write;
  logic                       wr_req;
  logic [32:0]                wr_data;
  logic                       pend_fail;
  logic                       trailer_done;

  logic        hdr_ok;
  logic [31:0] merged;
  logic [2:0]  merged_cnt;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = ((wr_ptr ^ rd_ptr) == PTR_FULL);
  assign fifo_pop  = !empty && m_axis.tready;
  assign can_write = !full || fifo_pop;
  assign hdr_ok    = pkt_header_valid_strobe && pkt_header_valid;

  assign m_axis.tvalid = !empty;
  assign m_axis.tdata  = empty ? 32'd0 : mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]][31:0];
  assign m_axis.tlast  = empty ? 1'b0  : mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]][32];
  assign busy          = (state != S_IDLE) || !empty;

  // Held word gets priority over the trailer so the trailer always sees final trunc state.
  always_comb begin
    wr_req       = 1'b0;
    wr_data      = 33'd0;
    pend_fail    = 1'b0;
    trailer_done = 1'b0;
    if (pend_vld) begin
      wr_data = {1'b0, pend_data};
      if (!trunc) begin
        wr_req    = can_write;
        pend_fail = !can_write;
      end
    end else if (state == S_TRAILER) begin
      wr_data      = {1'b1, byte_count, 13'd0, aborted, trunc, fcs_ok_reg};
      wr_req       = can_write;
      trailer_done = can_write;
    end
  end

  always_comb begin
    merged     = {8'd0, pack_word};
    merged_cnt = {1'b0, pack_cnt};
    if (byte_out_strobe) begin
      merged[{pack_cnt, 3'b000} +: 8] = byte_out;
      merged_cnt                      = {1'b0, pack_cnt} + 3'd1;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state           <= S_IDLE;
      pend_vld        <= 1'b0;
      pend_data       <= 32'd0;
      pack_word       <= 24'd0;
      pack_cnt        <= 2'd0;
      byte_count      <= 16'd0;
      trunc           <= 1'b0;
      aborted         <= 1'b0;
      fcs_ok_reg      <= 1'b0;
      pkt_drop_strobe <= 1'b0;
      overflow_cnt    <= 16'd0;
    end else begin
      pend_vld        <= 1'b0;
      pkt_drop_strobe <= 1'b0;
      if (pend_fail) begin
        trunc <= 1'b1;
        if (overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
      end
      case (state)
        S_IDLE: begin
          if (hdr_ok) begin
            if ((pkt_len > MAX_LEN) || full) begin
              pkt_drop_strobe <= 1'b1;
            end else begin
              pend_vld   <= 1'b1;
              pend_data  <= {6'd0, ht_sgi, ht_aggr, pkt_rate, pkt_len};
              pack_word  <= 24'd0;
              pack_cnt   <= 2'd0;
              byte_count <= 16'd0;
              trunc      <= 1'b0;
              aborted    <= 1'b0;
              fcs_ok_reg <= 1'b0;
              state      <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (byte_out_strobe) byte_count <= byte_count + 16'd1;
          // A new valid header mid-packet aborts the current one and is itself dropped.
          if (hdr_ok || fcs_out_strobe) begin
            if (merged_cnt != 3'd0) begin
              pend_vld  <= 1'b1;
              pend_data <= merged;
            end
            pack_word       <= 24'd0;
            pack_cnt        <= 2'd0;
            aborted         <= hdr_ok;
            fcs_ok_reg      <= !hdr_ok && fcs_ok;
            pkt_drop_strobe <= hdr_ok;
            state           <= S_TRAILER;
          end else if (merged_cnt == 3'd4) begin
            pend_vld  <= 1'b1;
            pend_data <= merged;
            pack_word <= 24'd0;
            pack_cnt  <= 2'd0;
          end else begin
            pack_word <= merged[23:0];
            pack_cnt  <= merged_cnt[1:0];
          end
        end
        S_TRAILER: begin
          if (hdr_ok) pkt_drop_strobe <= 1'b1;
          if (trailer_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_req)   wr_ptr <= wr_ptr + PTR_ONE;
      if (fifo_pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (wr_req) mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= wr_data;
  end

endmodule
